// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave controller.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } i2c_slv_state_t;

  localparam logic [6:0] I2C_GEN_CALL_ADDR = 7'h00;
  localparam int         I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// User-side byte interface of the I2C slave: TX byte request and RX byte delivery.
interface i2c_slave_ctrl_if;

  logic [7:0] i_tx_data;
  logic       o_tx_load;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_addr_match;
  logic       o_rw;
  logic       o_busy;

  modport slave (
    input  i_tx_data,
    output o_tx_load, o_rx_data, o_rx_valid, o_addr_match, o_rw, o_busy
  );

  modport master (
    output i_tx_data,
    input  o_tx_load, o_rx_data, o_rx_valid, o_addr_match, o_rw, o_busy
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection; flops preset to 1 so an idle bus looks idle.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave: START/STOP detect, address match, RX/TX shifting, open-drain SDA.
// Define I2C_GEN_CALL_EN to also acknowledge the general-call address (write only).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address byte + R/W
// ADDR_ACK  | driving address ACK for one SCL period
// RX_BYTE   | shifting in a data byte from the master
// RX_ACK    | driving data ACK for one SCL period
// TX_BYTE   | driving a data byte to the master
// TX_ACK    | sampling master ACK/NACK
// WAIT_STOP | not addressed or NACKed; waiting for STOP or START
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_scl,
  inout  tri                      io_sda,
  i2c_slave_ctrl_if.slave         if_usr
);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_ADDR      = ADDR;
  localparam logic [2:0] ST_ADDR_ACK  = ADDR_ACK;
  localparam logic [2:0] ST_RX_BYTE   = RX_BYTE;
  localparam logic [2:0] ST_RX_ACK    = RX_ACK;
  localparam logic [2:0] ST_TX_BYTE   = TX_BYTE;
  localparam logic [2:0] ST_TX_ACK    = TX_ACK;
  localparam logic [2:0] ST_WAIT_STOP = WAIT_STOP;
  localparam logic [2:0] LAST_BIT     = 3'(I2C_BITS_PER_BYTE - 1);

  logic       w_scl_s, w_scl_rise, w_scl_fall;
  logic       w_sda_s, w_sda_rise, w_sda_fall;
  logic       w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_addr_ok;

  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_tx_shift;
  logic       r_ack_phase;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_load;
  logic       r_addr_match;
  logic       r_rw;
  logic       r_busy;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_in    (i_scl),
    .o_level (w_scl_s),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_in    (io_sda),
    .o_level (w_sda_s),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_s;
  assign w_stop  = w_sda_rise & w_scl_s;
  assign w_byte  = {r_shift, w_sda_s};

`ifdef I2C_GEN_CALL_EN
  assign w_addr_ok = (r_shift == SLAVE_ADDR) ||
                     ((r_shift == I2C_GEN_CALL_ADDR) && !w_sda_s);
`else
  assign w_addr_ok = (r_shift == SLAVE_ADDR);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tx_shift   <= '0;
      r_ack_phase  <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_tx_load    <= 1'b0;
      r_addr_match <= 1'b0;
      r_rw         <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      if (w_start) begin
        r_state      <= ST_ADDR;
        r_bit_cnt    <= '0;
        r_addr_match <= 1'b0;
        r_sda_oe     <= 1'b0;
        r_busy       <= 1'b1;
      end else if (w_stop) begin
        r_state      <= ST_IDLE;
        r_bit_cnt    <= '0;
        r_addr_match <= 1'b0;
        r_sda_oe     <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == LAST_BIT) begin
                if (w_addr_ok) begin
                  r_state     <= ST_ADDR_ACK;
                  r_rw        <= w_sda_s;
                  r_ack_phase <= 1'b0;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_RX_ACK: begin
            // first SCL fall pulls SDA low, second one ends the ACK period
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
                if (r_state == ST_ADDR_ACK) r_addr_match <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                if ((r_state == ST_ADDR_ACK) && r_rw) begin
                  r_tx_load  <= 1'b1;
                  r_sda_oe   <= ~if_usr.i_tx_data[7];
                  r_tx_shift <= {if_usr.i_tx_data[6:0], 1'b0};
                  r_bit_cnt  <= 3'd1;
                  r_state    <= ST_TX_BYTE;
                end else begin
                  r_sda_oe  <= 1'b0;
                  r_bit_cnt <= '0;
                  r_state   <= ST_RX_BYTE;
                end
              end
            end
          end
          ST_RX_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == LAST_BIT) begin
                r_rx_data   <= w_byte;
                r_rx_valid  <= 1'b1;
                r_ack_phase <= 1'b0;
                r_state     <= ST_RX_ACK;
              end
            end
          end
          ST_TX_BYTE: begin
            // bit counter counts bits already put on SDA; wrap to 0 means all 8 are out
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_state     <= ST_TX_ACK;
              end else begin
                r_sda_oe   <= ~r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
              end
            end
          end
          ST_TX_ACK: begin
            if (w_scl_rise) begin
              if (w_sda_s) r_state <= ST_WAIT_STOP;
              else         r_ack_phase <= 1'b1;
            end else if (w_scl_fall && r_ack_phase) begin
              r_ack_phase <= 1'b0;
              r_tx_load   <= 1'b1;
              r_sda_oe    <= ~if_usr.i_tx_data[7];
              r_tx_shift  <= {if_usr.i_tx_data[6:0], 1'b0};
              r_bit_cnt   <= 3'd1;
              r_state     <= ST_TX_BYTE;
            end
          end
          ST_IDLE, ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_sda              = r_sda_oe ? 1'b0 : 1'bz;
  assign if_usr.o_tx_load    = r_tx_load;
  assign if_usr.o_rx_data    = r_rx_data;
  assign if_usr.o_rx_valid   = r_rx_valid;
  assign if_usr.o_addr_match = r_addr_match;
  assign if_usr.o_rw         = r_rw;
  assign if_usr.o_busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: bit-banged I2C master with hand-computed expectations.
module tb_i2c_slave_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic m_oe;
  wire  sda;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rx_pulses = 0;
  int   tx_pulses = 0;

  i2c_slave_ctrl_if u_if ();

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_scl   (scl),
    .io_sda  (sda),
    .if_usr  (u_if.slave)
  );

  always @(negedge clk) begin
    if (u_if.o_rx_valid) rx_pulses++;
    if (u_if.o_tx_load)  tx_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_oe = ~b;
    tick(5);
    scl = 1'b1;
    tick(5);
    s = sda;
    tick(5);
    scl = 1'b0;
    tick(5);
  endtask

  task automatic m_start;
    m_oe = 1'b0;
    tick(5);
    scl = 1'b1;
    tick(10);
    m_oe = 1'b1;
    tick(10);
    scl = 1'b0;
    tick(5);
  endtask

  task automatic m_stop;
    m_oe = 1'b1;
    tick(5);
    scl = 1'b1;
    tick(10);
    m_oe = 1'b0;
    tick(10);
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(~master_ack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    logic [7:0] b8;
    int         rx0, tx0;

    rst = 1'b1;
    scl = 1'b1;
    m_oe = 1'b0;
    u_if.i_tx_data = 8'h00;
    tick(3);
    chk("rst_rx_data", u_if.o_rx_data, 8'h00);
    chk("rst_rx_valid", u_if.o_rx_valid, 0);
    chk("rst_tx_load", u_if.o_tx_load, 0);
    chk("rst_addr_match", u_if.o_addr_match, 0);
    chk("rst_rw", u_if.o_rw, 0);
    chk("rst_busy", u_if.o_busy, 0);
    chk("rst_sda", sda, 1);
    rst = 1'b0;
    tick(10);

    // write 0xA5 to 0x42
    rx0 = rx_pulses;
    m_start;
    chk("wr_busy", u_if.o_busy, 1);
    m_write(8'h84, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_addr_match", u_if.o_addr_match, 1);
    chk("wr_rw", u_if.o_rw, 0);
    m_write(8'hA5, ack);
    chk("wr_data_ack", ack, 0);
    chk("wr_rx_data", u_if.o_rx_data, 8'hA5);
    chk("wr_rx_pulses", rx_pulses - rx0, 1);
    m_stop;
    tick(5);
    chk("wr_busy_end", u_if.o_busy, 0);
    chk("wr_match_end", u_if.o_addr_match, 0);

    // wrong address 0x43
    rx0 = rx_pulses;
    m_start;
    m_write(8'h86, ack);
    chk("na_addr_nack", ack, 1);
    chk("na_addr_match", u_if.o_addr_match, 0);
    m_write(8'h55, ack);
    chk("na_data_nack", ack, 1);
    chk("na_rx_pulses", rx_pulses - rx0, 0);
    m_stop;
    tick(5);
    chk("na_busy_end", u_if.o_busy, 0);

    // read 0x3C then 0x81 from 0x42
    tx0 = tx_pulses;
    u_if.i_tx_data = 8'h3C;
    m_start;
    m_write(8'h85, ack);
    chk("rd_addr_ack", ack, 0);
    chk("rd_rw", u_if.o_rw, 1);
    chk("rd_load1", tx_pulses - tx0, 1);
    u_if.i_tx_data = 8'h81;
    m_read(1'b1, d);
    chk("rd_byte1", d, 8'h3C);
    m_read(1'b0, d);
    chk("rd_byte2", d, 8'h81);
    chk("rd_load2", tx_pulses - tx0, 2);
    tick(3);
    chk("rd_sda_released", sda, 1);
    m_stop;
    tick(5);
    chk("rd_busy_end", u_if.o_busy, 0);

    // partial write byte aborted by repeated START, then read
    rx0 = rx_pulses;
    u_if.i_tx_data = 8'h5A;
    m_start;
    m_write(8'h84, ack);
    chk("rs_addr_ack", ack, 0);
    m_bit(1'b1, s);
    m_bit(1'b0, s);
    m_bit(1'b1, s);
    m_bit(1'b1, s);
    m_start;
    chk("rs_match_clr", u_if.o_addr_match, 0);
    m_write(8'h85, ack);
    chk("rs_addr2_ack", ack, 0);
    chk("rs_rw", u_if.o_rw, 1);
    m_read(1'b0, d);
    chk("rs_byte", d, 8'h5A);
    chk("rs_rx_pulses", rx_pulses - rx0, 0);
    m_stop;
    tick(5);

    // reset while the slave pulls the address ACK low
    b8 = 8'h84;
    m_start;
    for (int i = 7; i >= 0; i--) m_bit(b8[i], s);
    m_oe = 1'b0;
    tick(5);
    scl = 1'b1;
    tick(3);
    chk("rst_mid_sda_low", sda, 0);
    chk("rst_mid_match", u_if.o_addr_match, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_sda_rel", sda, 1);
    chk("rst_mid_busy", u_if.o_busy, 0);
    chk("rst_mid_match0", u_if.o_addr_match, 0);
    chk("rst_mid_rx_data", u_if.o_rx_data, 8'h00);
    chk("rst_mid_rw", u_if.o_rw, 0);
    scl = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(5);
    m_stop;
    tick(5);
    chk("rst_mid_idle", u_if.o_busy, 0);

    // general call address
    rx0 = rx_pulses;
    m_start;
    m_write(8'h00, ack);
`ifdef I2C_GEN_CALL_EN
    chk("gc_addr_ack", ack, 0);
    m_write(8'h06, ack);
    chk("gc_data_ack", ack, 0);
    chk("gc_rx_data", u_if.o_rx_data, 8'h06);
    chk("gc_rx_pulses", rx_pulses - rx0, 1);
`else
    chk("gc_addr_nack", ack, 1);
    m_write(8'h06, ack);
    chk("gc_rx_pulses", rx_pulses - rx0, 0);
`endif
    m_stop;
    tick(5);
    chk("gc_busy_end", u_if.o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Byte-level I2C slave controller that sequences the shared SDA line: detects START/STOP, matches the 7-bit address, shifts data in and out, and schedules when the slave samples or drives SDA (ACK, read data).
- Sits between the I2C pins and a register-file or user interface, presenting received bytes and requesting bytes to transmit.
- SDA is driven open-drain (low or Z only).

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this slave acknowledges.
- SYNC_STAGES, 2, flop depth of the SCL/SDA input synchronizers (min 2).

Ports:
- i_clk  in  1  system clock; must be at least 8x SCL.
- i_reset  in  1  synchronous, active-high reset.
- i_scl  in  1  I2C clock from the master (asynchronous).
- io_sda  inout tri  1  I2C data; `io_sda = sda_oe ? 1'b0 : 1'bz`.
- i_tx_data  in  8  byte to send on the next read byte; sampled on the o_tx_load cycle.
- o_tx_load  out  1  1-cycle pulse: i_tx_data captured into the TX shifter.
- o_rx_data  out  8  last received data byte; held until the next one.
- o_rx_valid  out  1  1-cycle pulse when o_rx_data updates.
- o_addr_match  out  1  high from an address ACK until STOP or repeated START.
- o_rw  out  1  R/W bit of the current transaction (1 = read).
- o_busy  out  1  high from START until STOP.

Behaviour:
- Reset:
  - State = IDLE; sda_oe = 0 (SDA released).
  - o_rx_data = 0; o_rx_valid, o_tx_load, o_addr_match, o_rw, o_busy = 0.
  - Bit counter = 0.
  - Synchronizer flops preset to 1 (bus idle).
  - Reset mid-transfer releases SDA on the next clock edge.
- Synchronization and bus conditions:
  - i_scl and io_sda each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies: scl_rise, scl_fall, sda_rise, sda_fall.
  - START = sda_fall while scl_s == 1. STOP = sda_rise while scl_s == 1.
- Sampling and driving:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, so SDA never changes while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on scl_rise. After the 8th bit, go to ADDR_ACK if addr == SLAVE_ADDR, else WAIT_STOP.
  - ADDR_ACK: on scl_fall, sda_oe = 1. On the next scl_fall, sda_oe released. Then:
    - read: TX_BYTE with o_tx_load pulsed on entry, and bit 7 driven on the same scl_fall.
    - write: RX_BYTE.
  - RX_BYTE: shift 8 bits on scl_rise. After the 8th, o_rx_data updates and o_rx_valid pulses in the following cycle, then RX_ACK.
  - RX_ACK: drive ACK low for one SCL period exactly as in ADDR_ACK, then RX_BYTE.
  - TX_BYTE: on each scl_fall, sda_oe = ~tx_shift[7] and the shifter moves left. After the 8th bit's scl_fall, SDA is released and the state is TX_ACK.
  - TX_ACK: sample the master ACK on scl_rise.
    - 0 (ACK): on scl_fall, pulse o_tx_load and go to TX_BYTE.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Global conditions (any state):
  - STOP: go to IDLE, release SDA, clear o_busy and o_addr_match.
  - START (including repeated START): go to ADDR, bit counter = 0, clear o_addr_match, release SDA.
  - Priority: reset > START/STOP > shift/ACK.
- Bit counter:
  - 3-bit, wraps 7 -> 0.
  - A partial byte interrupted by START or STOP is discarded: no o_rx_valid.
- o_rw latches bit 0 of the address byte at ADDR_ACK entry.

Optional Feature:
- Macro I2C_GEN_CALL_EN.
- Defined: address byte 8'h00 (general call, write) is also ACKed, and the transaction proceeds as a write. General call with R/W = 1 is NACKed (WAIT_STOP).
- Undefined: only SLAVE_ADDR is ACKed.

Decomposition:
- Package i2c_slave_pkg:
  - state enum `i2c_slv_state_t` (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP).
  - constants `I2C_GEN_CALL_ADDR = 7'h00` and `I2C_BITS_PER_BYTE = 8`.
- Sub-module i2c_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, preset to 1 on reset. Instantiated twice, for SCL and SDA.

Test Plan:
- START, address 0x42 write (0x84), data 0xA5, STOP -> SDA held low during both ACK clocks; o_rx_data = 0xA5 with one o_rx_valid pulse; o_busy falls after STOP.
- START, address 0x43 write -> no ACK (SDA stays Z/1 on the 9th clock); no o_rx_valid; state returns to IDLE on STOP.
- START, address 0x42 read, i_tx_data = 0x3C then 0x81, master ACKs byte 1 and NACKs byte 2 -> SDA carries 0x3C then 0x81; two o_tx_load pulses; SDA released after the NACK.
- Write 0x42, partial byte (4 bits), then repeated START + read 0x42 -> no o_rx_valid; o_rw = 1; read proceeds normally.
- i_reset asserted while the slave is driving an ACK low -> SDA released within 1 cycle; all outputs at their reset values.
- With I2C_GEN_CALL_EN defined: START, address byte 0x00 -> ACK; data 0x06 received. Without the macro: NACK.
